// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 UART transmitter with a one-byte holding register.
//
// A byte offered on tx_req is captured into a holding register whenever it is
// empty; the FSM moves it into the shift register at the start of each frame,
// so one byte can be queued while another is on the line.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous, active-high reset
//   tx_req    single-cycle request to send tx_data
//   tx_data   byte to send, sampled only when tx_req is accepted
//   tx        registered serial output, idle high
//   tx_empty  holding register can accept a byte
//   tx_busy   a frame (start, data or stop) is on the line
//   tx_error  sticky overrun flag; cleared by rst or the next accepted byte
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       tx_error
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            stop_idx_q, stop_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            tx_q, tx_d;
  logic            err_q, err_d;

  logic baud_end;
  logic last_stop;
  logic load_hold;

  assign baud_end  = (baud_q == CntLast);
  // With one stop bit every stop period is the last one.
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx_q;

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_end ? '0 : baud_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;
    err_d       = err_q;
    load_hold   = 1'b0;

    case (state_q)
      StIdle: begin
        baud_d = '0;
        if (hold_full_q) begin
          load_hold = 1'b1;
        end
      end
      StStart: begin
        if (baud_end) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      StData: begin
        if (baud_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d    = StStop;
            stop_idx_d = 1'b0;
            tx_d       = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      StStop: begin
        if (baud_end) begin
          if (last_stop) begin
            // A queued byte starts its frame with no idle gap.
            if (hold_full_q) begin
              load_hold = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    if (load_hold) begin
      state_d     = StStart;
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      baud_d      = '0;
      tx_d        = 1'b0;
    end

    // Acceptance is decided on the registered hold_full, so a request in the
    // cycle of a hold-to-shifter transfer is an overrun; the two never collide.
    if (tx_req) begin
      if (!hold_full_q) begin
        hold_d      = tx_data;
        hold_full_d = 1'b1;
        err_d       = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      baud_q      <= '0;
      bit_idx_q   <= 3'd0;
      stop_idx_q  <= 1'b0;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      err_q       <= err_d;
    end
  end

  assign tx       = tx_q;
  assign tx_empty = ~hold_full_q;
  assign tx_busy  = (state_q != StIdle);
  assign tx_error = err_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: CLKS_PER_BIT=4 with one stop bit (u_dut) and with two
// stop bits (u_dut2). A line monitor decodes frames from u_dut into rx_q; each
// accepted byte is pushed to exp_q and the two queues are compared in order.
module tb_uart_tx;

  localparam int unsigned Cpb = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, tx_empty, tx_busy, tx_error;
  logic       tx_req2 = 1'b0;
  logic [7:0] tx_data2 = 8'h00;
  logic       tx2, tx_empty2, tx_busy2, tx_error2;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         stop_err = 0;

  logic c_tx[128];
  logic c_busy[128];
  logic c_empty[128];
  logic c_tx2[128];
  logic c_busy2[128];

  uart_tx #(.CLKS_PER_BIT(Cpb), .STOP_BITS(1)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .tx       (tx),
    .tx_empty (tx_empty),
    .tx_busy  (tx_busy),
    .tx_error (tx_error)
  );

  uart_tx #(.CLKS_PER_BIT(Cpb), .STOP_BITS(2)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .tx_req   (tx_req2),
    .tx_data  (tx_data2),
    .tx       (tx2),
    .tx_empty (tx_empty2),
    .tx_busy  (tx_busy2),
    .tx_error (tx_error2)
  );

  always #5 clk = ~clk;

  // Frame decoder for u_dut: samples mid-bit on the falling edge.
  initial begin
    int         mcnt;
    bit         mact;
    logic [7:0] msh;
    mcnt = 0;
    mact = 1'b0;
    msh  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        mact = 1'b0;
      end else if (!mact) begin
        if (tx === 1'b0) begin
          mact = 1'b1;
          mcnt = 0;
        end
      end else begin
        mcnt++;
        if (mcnt >= 6 && mcnt <= 34 && (mcnt % 4) == 2) msh[(mcnt - 6) / 4] = tx;
        if (mcnt == 38) begin
          rx_q.push_back(msh);
          if (tx !== 1'b1) stop_err++;
        end
        if (mcnt == 39) mact = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input int k);
    c_tx[k]    = tx;
    c_busy[k]  = tx_busy;
    c_empty[k] = tx_empty;
    c_tx2[k]   = tx2;
    c_busy2[k] = tx_busy2;
  endtask

  // Expected line level j cycles into a frame (j=0 is the first start cycle).
  function automatic logic frame_bit(input int j, input logic [7:0] b);
    if (j < 4) return 1'b0;
    if (j < 36) return b[(j - 4) / 4];
    return 1'b1;
  endfunction

  task automatic do_reset();
    tx_req  = 1'b0;
    tx_req2 = 1'b0;
    rst     = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_reset();
    int lows;
    rst     = 1'b1;
    tx_req  = 1'b0;
    tx_data = 8'hC3;
    tick();
    tick();
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (tx_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", tx_empty); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    n_cmp++; if (tx_error !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b want 0", tx_error); end
    n_cmp++; if (tx2 !== 1'b1) begin n_err++; $display("FAIL reset_tx2: got %b want 1", tx2); end
    rst = 1'b0;
    lows = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    n_cmp++; if (lows != 0) begin n_err++; $display("FAIL reset_idle_line: got %0d non-idle cycles want 0", lows); end
    rx_q.delete();
  endtask

  task automatic test_single();
    logic [127:0] o_tx, e_tx, o_busy, e_busy, o_emp, e_emp;
    int nb, ne;
    logic [7:0] got, want;
    do_reset();
    tx_req = 1'b1; tx_data = 8'hA5;
    tick();
    tx_req = 1'b0; tx_data = 8'h5A;
    exp_q.push_back(8'hA5);
    samp(0);
    for (int k = 1; k < 48; k++) begin tick(); samp(k); end
    o_tx = '0; e_tx = '0; o_busy = '0; e_busy = '0; o_emp = '0; e_emp = '0;
    nb = 0; ne = 0;
    for (int k = 0; k < 48; k++) begin
      o_tx[k]   = c_tx[k];
      o_busy[k] = c_busy[k];
      o_emp[k]  = c_empty[k];
      e_tx[k]   = (k >= 1 && k <= 40) ? frame_bit(k - 1, 8'hA5) : 1'b1;
      e_busy[k] = (k >= 1 && k <= 40);
      e_emp[k]  = (k != 0);
      if (c_busy[k] === 1'b1) nb++;
      if (c_empty[k] === 1'b0) ne++;
    end
    n_cmp++; if (o_tx !== e_tx) begin n_err++; $display("FAIL single_tx: got %h want %h", o_tx, e_tx); end
    n_cmp++; if (o_busy !== e_busy) begin n_err++; $display("FAIL single_busy: got %h want %h", o_busy, e_busy); end
    n_cmp++; if (o_emp !== e_emp) begin n_err++; $display("FAIL single_empty: got %h want %h", o_emp, e_emp); end
    n_cmp++; if (nb != 40) begin n_err++; $display("FAIL single_busy_len: got %0d want 40", nb); end
    n_cmp++; if (ne != 1) begin n_err++; $display("FAIL single_empty_len: got %0d want 1", ne); end
    n_cmp++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL single_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
    while (rx_q.size() != 0) begin
      got  = rx_q.pop_front();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL single_byte: got %h want %h", got, want); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] o_tx, e_tx, o_busy, e_busy, o_emp, e_emp;
    int nb;
    logic [7:0] got, want;
    do_reset();
    tx_req = 1'b1; tx_data = 8'h00;
    tick();
    tx_req = 1'b0; tx_data = 8'hE7;
    exp_q.push_back(8'h00);
    samp(0);
    for (int k = 1; k < 5; k++) begin tick(); samp(k); end
    tx_req = 1'b1; tx_data = 8'hFF;
    tick();
    tx_req = 1'b0; tx_data = 8'h18;
    exp_q.push_back(8'hFF);
    samp(5);
    for (int k = 6; k < 90; k++) begin tick(); samp(k); end
    o_tx = '0; e_tx = '0; o_busy = '0; e_busy = '0; o_emp = '0; e_emp = '0;
    nb = 0;
    for (int k = 0; k < 90; k++) begin
      o_tx[k]   = c_tx[k];
      o_busy[k] = c_busy[k];
      o_emp[k]  = c_empty[k];
      if (k >= 1 && k <= 40) e_tx[k] = frame_bit(k - 1, 8'h00);
      else if (k >= 41 && k <= 80) e_tx[k] = frame_bit(k - 41, 8'hFF);
      else e_tx[k] = 1'b1;
      e_busy[k] = (k >= 1 && k <= 80);
      e_emp[k]  = !(k == 0 || (k >= 5 && k <= 40));
      if (c_busy[k] === 1'b1) nb++;
    end
    n_cmp++; if (o_tx !== e_tx) begin n_err++; $display("FAIL b2b_tx: got %h want %h", o_tx, e_tx); end
    n_cmp++; if (o_busy !== e_busy) begin n_err++; $display("FAIL b2b_busy: got %h want %h", o_busy, e_busy); end
    n_cmp++; if (o_emp !== e_emp) begin n_err++; $display("FAIL b2b_empty: got %h want %h", o_emp, e_emp); end
    n_cmp++; if (nb != 80) begin n_err++; $display("FAIL b2b_busy_len: got %0d want 80", nb); end
    n_cmp++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
    while (rx_q.size() != 0) begin
      got  = rx_q.pop_front();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL b2b_byte: got %h want %h", got, want); end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] got, want;
    do_reset();
    tx_req = 1'b1; tx_data = 8'h11;
    tick();
    exp_q.push_back(8'h11);
    tx_req = 1'b0;
    tick();
    tx_req = 1'b1; tx_data = 8'h22;
    tick();
    exp_q.push_back(8'h22);
    n_cmp++; if (tx_error !== 1'b0) begin n_err++; $display("FAIL ovr_err_before: got %b want 0", tx_error); end
    n_cmp++; if (tx_empty !== 1'b0) begin n_err++; $display("FAIL ovr_empty: got %b want 0", tx_empty); end
    tx_data = 8'h33;
    tick();
    tx_req = 1'b0; tx_data = 8'h00;
    n_cmp++; if (tx_error !== 1'b1) begin n_err++; $display("FAIL ovr_err_set: got %b want 1", tx_error); end
    for (int k = 0; k < 90; k++) tick();
    n_cmp++; if (tx_error !== 1'b1) begin n_err++; $display("FAIL ovr_err_sticky: got %b want 1", tx_error); end
    n_cmp++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovr_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
    while (rx_q.size() != 0) begin
      got  = rx_q.pop_front();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL ovr_byte: got %h want %h", got, want); end
    end
    exp_q.delete();
    tx_req = 1'b1; tx_data = 8'h44;
    tick();
    tx_req = 1'b0;
    exp_q.push_back(8'h44);
    n_cmp++; if (tx_error !== 1'b0) begin n_err++; $display("FAIL ovr_err_clear: got %b want 0", tx_error); end
    for (int k = 0; k < 48; k++) tick();
    n_cmp++; if (rx_q.size() != 1) begin n_err++; $display("FAIL ovr_count2: got %0d want 1", rx_q.size()); end
    while (rx_q.size() != 0) begin
      got  = rx_q.pop_front();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL ovr_byte2: got %h want %h", got, want); end
    end
  endtask

  task automatic test_coincide();
    logic [7:0] got, want;
    do_reset();
    tx_req = 1'b1; tx_data = 8'h55;
    tick();
    exp_q.push_back(8'h55);
    tx_data = 8'h66;
    tick();
    tx_req = 1'b0;
    n_cmp++; if (tx_error !== 1'b1) begin n_err++; $display("FAIL coin_err: got %b want 1", tx_error); end
    n_cmp++; if (tx_empty !== 1'b1) begin n_err++; $display("FAIL coin_empty: got %b want 1", tx_empty); end
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL coin_start: got %b want 0", tx); end
    for (int k = 0; k < 50; k++) tick();
    n_cmp++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL coin_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
    while (rx_q.size() != 0) begin
      got  = rx_q.pop_front();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL coin_byte: got %h want %h", got, want); end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    tx_req = 1'b1; tx_data = 8'h5A;
    tick();
    tx_req = 1'b0;
    exp_q.push_back(8'h5A);
    for (int k = 1; k < 4; k++) tick();
    tx_req = 1'b1; tx_data = 8'h3C;
    tick();
    tx_req = 1'b0;
    for (int k = 5; k < 15; k++) tick();
    rst = 1'b1; tx_data = 8'h81; tx_req = 1'b1;
    tick();
    rst = 1'b0; tx_req = 1'b0;
    exp_q.delete();
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL mid_tx: got %b want 1", tx); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", tx_busy); end
    n_cmp++; if (tx_empty !== 1'b1) begin n_err++; $display("FAIL mid_empty: got %b want 1", tx_empty); end
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL mid_residual: got %0d active cycles want 0", bad); end
    n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL mid_frames: got %0d want 0", rx_q.size()); end
  endtask

  task automatic test_stop2();
    logic [127:0] o_tx, e_tx, o_busy, e_busy;
    logic [7:0]   b;
    int nb;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      b = (f == 0) ? 8'hFF : 8'h00;
      tx_req2 = 1'b1; tx_data2 = b;
      tick();
      tx_req2 = 1'b0; tx_data2 = ~b;
      samp(0);
      for (int k = 1; k < 50; k++) begin tick(); samp(k); end
      o_tx = '0; e_tx = '0; o_busy = '0; e_busy = '0;
      nb = 0;
      for (int k = 0; k < 50; k++) begin
        o_tx[k]   = c_tx2[k];
        o_busy[k] = c_busy2[k];
        e_tx[k]   = (k >= 1 && k <= 44) ? frame_bit(k - 1, b) : 1'b1;
        e_busy[k] = (k >= 1 && k <= 44);
        if (c_busy2[k] === 1'b1) nb++;
      end
      n_cmp++; if (o_tx !== e_tx) begin n_err++; $display("FAIL stop2_tx[%h]: got %h want %h", b, o_tx, e_tx); end
      n_cmp++; if (o_busy !== e_busy) begin n_err++; $display("FAIL stop2_busy[%h]: got %h want %h", b, o_busy, e_busy); end
      n_cmp++; if (nb != 44) begin n_err++; $display("FAIL stop2_len[%h]: got %0d want 44", b, nb); end
    end
    n_cmp++; if (stop_err != 0) begin n_err++; $display("FAIL stop_bits_seen: got %0d bad stop bits want 0", stop_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_coincide();
    test_reset_mid();
    test_stop2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
